// File: rtl/rst_seq_pkg.sv
// rst_seq_pkg: shared FSM state type and counter sizing for the reset sequencer.
package rst_seq_pkg;

    typedef enum logic [2:0] {
        WAIT_LOCK,
        STABLE,
        REL_BOOT,
        REL_UART,
        REL_CORE,
        RUN,
        SW_RST
    } state_t;

    // Width of a counter that must reach (largest limit - 1).
    function automatic int cnt_width(input int a, input int b, input int c, input int d, input int e);
        int m;
        m = a;
        m = (b > m) ? b : m;
        m = (c > m) ? c : m;
        m = (d > m) ? d : m;
        m = (e > m) ? e : m;
        return (m > 2) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/rst_sequencer_if.sv
// rst_sequencer_if: lock/request inputs and domain reset outputs of the reset sequencer.
interface rst_sequencer_if;

    logic pll_locked;
    logic sw_rst_req;
    logic sys_rst_n;
    logic boot_rst_n;
    logic uart_rst_n;
    logic core_rst_n;
    logic seq_done;
    logic pll_rst;
    logic lock_timeout;

    modport master (
        input  pll_locked, sw_rst_req,
        output sys_rst_n, boot_rst_n, uart_rst_n, core_rst_n, seq_done, pll_rst, lock_timeout
    );

    modport slave (
        output pll_locked, sw_rst_req,
        input  sys_rst_n, boot_rst_n, uart_rst_n, core_rst_n, seq_done, pll_rst, lock_timeout
    );

endinterface

// File: rtl/rst_sequencer_sync_ff.sv
// sync_ff: STAGES-deep single-bit synchronizer, flops cleared to 0 by rst.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q, sync_d;

    always_comb sync_d = {sync_q[STAGES-2:0], d};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= '0;
        else     sync_q <= sync_d;
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/rst_sequencer.sv
// rst_sequencer: releases boot, uart then core resets once PLL lock is stable.
// Define RST_SEQ_WDOG_EN for the lock watchdog that pulses pll_rst and flags lock_timeout.
module rst_sequencer
    import rst_seq_pkg::*;
#(
    parameter int SYNC_STAGES        = 2,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int STAGE_GAP          = 16,
    parameter int SW_RST_CYCLES      = 32,
    parameter int LOCK_TIMEOUT       = 65536,
    parameter int PLL_RST_CYCLES     = 8
) (
    input logic             clk,
    input logic             rst,
    rst_sequencer_if.master bus
);

    localparam int CW = cnt_width(LOCK_STABLE_CYCLES, STAGE_GAP, SW_RST_CYCLES, LOCK_TIMEOUT, PLL_RST_CYCLES);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          locked_s, wdog_fire, cnt_idle;
    logic          sys_rst_n_q, sys_rst_n_d;
    logic          boot_rst_n_q, boot_rst_n_d;
    logic          uart_rst_n_q, uart_rst_n_d;
    logic          core_rst_n_q, core_rst_n_d;
    logic          seq_done_q, seq_done_d;

    sync_ff #(.STAGES(SYNC_STAGES)) u_lock_sync (
        .clk (clk),
        .rst (rst),
        .d   (bus.pll_locked),
        .q   (locked_s)
    );

    // Lock loss outranks every other transition, then sw request, then counter expiry.
    always_comb begin
        state_d = state_q;
        if (state_q != WAIT_LOCK && !locked_s) begin
            state_d = WAIT_LOCK;
        end else begin
            case (state_q)
                WAIT_LOCK: if (locked_s) state_d = STABLE;
                STABLE:    if (cnt_q == CW'(LOCK_STABLE_CYCLES - 1)) state_d = REL_BOOT;
                REL_BOOT:  if (cnt_q == CW'(STAGE_GAP - 1)) state_d = REL_UART;
                REL_UART:  if (cnt_q == CW'(STAGE_GAP - 1)) state_d = REL_CORE;
                REL_CORE:  if (cnt_q == CW'(STAGE_GAP - 1)) state_d = RUN;
                RUN:       if (bus.sw_rst_req) state_d = SW_RST;
                SW_RST:    if (cnt_q == CW'(SW_RST_CYCLES - 1)) state_d = RUN;
                default:   state_d = WAIT_LOCK;
            endcase
        end
        cnt_d        = (state_d != state_q || cnt_idle || wdog_fire) ? '0 : cnt_q + CW'(1);
        sys_rst_n_d  = state_d inside {REL_BOOT, REL_UART, REL_CORE, RUN, SW_RST};
        boot_rst_n_d = state_d inside {REL_BOOT, REL_UART, REL_CORE, RUN, SW_RST};
        uart_rst_n_d = state_d inside {REL_UART, REL_CORE, RUN, SW_RST};
        core_rst_n_d = state_d inside {REL_CORE, RUN};
        seq_done_d   = state_d == RUN;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= WAIT_LOCK;
            cnt_q        <= '0;
            sys_rst_n_q  <= 1'b0;
            boot_rst_n_q <= 1'b0;
            uart_rst_n_q <= 1'b0;
            core_rst_n_q <= 1'b0;
            seq_done_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sys_rst_n_q  <= sys_rst_n_d;
            boot_rst_n_q <= boot_rst_n_d;
            uart_rst_n_q <= uart_rst_n_d;
            core_rst_n_q <= core_rst_n_d;
            seq_done_q   <= seq_done_d;
        end
    end

    assign bus.sys_rst_n  = sys_rst_n_q;
    assign bus.boot_rst_n = boot_rst_n_q;
    assign bus.uart_rst_n = uart_rst_n_q;
    assign bus.core_rst_n = core_rst_n_q;
    assign bus.seq_done   = seq_done_q;

`ifdef RST_SEQ_WDOG_EN
    localparam int PW = $clog2(PLL_RST_CYCLES + 1);

    logic [PW-1:0] prc_q, prc_d;
    logic          pll_rst_q, pll_rst_d;
    logic          lock_timeout_q, lock_timeout_d;

    // The shared counter doubles as the lock watchdog while waiting for lock.
    assign wdog_fire = state_q == WAIT_LOCK && !locked_s && cnt_q == CW'(LOCK_TIMEOUT - 1);
    assign cnt_idle  = state_q == RUN;

    always_comb begin
        prc_d          = wdog_fire ? PW'(PLL_RST_CYCLES) : (prc_q != '0 ? prc_q - PW'(1) : '0);
        pll_rst_d      = prc_d != '0;
        lock_timeout_d = wdog_fire || (lock_timeout_q && !(state_q == STABLE && state_d == REL_BOOT));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prc_q          <= '0;
            pll_rst_q      <= 1'b0;
            lock_timeout_q <= 1'b0;
        end else begin
            prc_q          <= prc_d;
            pll_rst_q      <= pll_rst_d;
            lock_timeout_q <= lock_timeout_d;
        end
    end

    assign bus.pll_rst      = pll_rst_q;
    assign bus.lock_timeout = lock_timeout_q;
`else
    assign wdog_fire        = 1'b0;
    assign cnt_idle         = state_q inside {WAIT_LOCK, RUN};
    assign bus.pll_rst      = 1'b0;
    assign bus.lock_timeout = 1'b0;
`endif

endmodule

// File: doc/rst_sequencer.md
Name: rst_sequencer

Overview:
- Consumes the clock generator's PLL `locked` indication and produces the sequenced, synchronous-deassert resets for the boot, UART and core domains, plus the system reset `sys_rst_n`.
- Sits directly after the clock generator in the top level and runs on the 100MHz output clock.
- Re-asserts all resets on loss of lock.
- Supports a software core-only reset.

Parameters:
- SYNC_STAGES, 2: flops in the `pll_locked` synchronizer (min 2).
- LOCK_STABLE_CYCLES, 1024: consecutive synchronized-lock cycles required before release (min 1).
- STAGE_GAP, 16: cycles between successive domain releases (min 1).
- SW_RST_CYCLES, 32: core reset pulse length for a software reset (min 1).
- LOCK_TIMEOUT, 65536: watchdog limit in WAIT_LOCK (used only with the optional feature).
- PLL_RST_CYCLES, 8: PLL reset pulse length (used only with the optional feature).

Ports:
- clk  in  1  system clock, 100MHz from clock generator
- rst  in  1  asynchronous, active-high reset
- pll_locked  in  1  PLL lock, asynchronous to clk
- sw_rst_req  in  1  single-cycle software core-reset request
- sys_rst_n  out  1  system reset, active low
- boot_rst_n  out  1  boot domain reset, active low
- uart_rst_n  out  1  UART domain reset, active low
- core_rst_n  out  1  core domain reset, active low
- seq_done  out  1  high while fully out of reset (RUN)
- pll_rst  out  1  active-high reset back to the clock generator
- lock_timeout  out  1  sticky watchdog flag

Behaviour:
- All outputs are registered and asynchronously cleared by `rst`.
- Reset values: all `*_rst_n` = 0; `seq_done`, `pll_rst`, `lock_timeout` = 0.
- `pll_locked` passes through SYNC_STAGES flops to form `locked_s`. Flops reset to 0.
- One counter, `cnt`, sized for max(LOCK_STABLE_CYCLES, STAGE_GAP, SW_RST_CYCLES, LOCK_TIMEOUT). It is cleared on every state change.
- FSM states: WAIT_LOCK (reset state), STABLE, REL_BOOT, REL_UART, REL_CORE, RUN, SW_RST.
- WAIT_LOCK: all resets asserted. Go to STABLE when `locked_s` = 1.
- STABLE: counts cycles with `locked_s` = 1. At cnt == LOCK_STABLE_CYCLES-1, go to REL_BOOT.
- REL_BOOT: from its first cycle, `sys_rst_n` = 1 and `boot_rst_n` = 1. After STAGE_GAP cycles, go to REL_UART.
- REL_UART: `uart_rst_n` = 1 from its first cycle. After STAGE_GAP cycles, go to REL_CORE.
- REL_CORE: `core_rst_n` = 1 from its first cycle. After STAGE_GAP cycles, go to RUN.
- RUN: `seq_done` = 1. On `sw_rst_req` = 1, go to SW_RST.
- SW_RST: `core_rst_n` = 0 and `seq_done` = 0 for SW_RST_CYCLES cycles; other resets stay released. Then return to RUN.
- Release order is strict: boot, then uart, then core. Reassertion on lock loss is simultaneous for all domains.
- Lock loss: `locked_s` = 0 in any state other than WAIT_LOCK sends the FSM to WAIT_LOCK next cycle. All resets and `seq_done` drop on that transition. The stability count restarts from zero.
- Priority: lock loss > `sw_rst_req` > counter expiry.
- `sw_rst_req` outside RUN is ignored and not queued. A new request during SW_RST is ignored.
- `rst` mid-sequence returns the block to the reset state immediately (asynchronous).

Optional Feature:
- Macro: RST_SEQ_WDOG_EN.
- Defined: in WAIT_LOCK, `cnt` counts up. When cnt == LOCK_TIMEOUT-1:
  - `lock_timeout` is set;
  - `pll_rst` is driven high for PLL_RST_CYCLES;
  - `cnt` is cleared and the FSM stays in WAIT_LOCK;
  - the cycle repeats until lock is seen.
- `lock_timeout` clears when STABLE completes (entry to REL_BOOT) or on `rst`.
- Not defined: `pll_rst` and `lock_timeout` are tied 0 and the WAIT_LOCK counter is absent. Ports remain present.

Decomposition:
- Package `rst_seq_pkg`: FSM state enum and the counter-width function (clog2 of the max parameter).
- Sub-module `sync_ff` (SYNC_STAGES-deep, reset-to-0 bit synchronizer), also reusable elsewhere.

Test Plan:
Parameters for all scenarios: SYNC_STAGES=2, LOCK_STABLE_CYCLES=16, STAGE_GAP=4, SW_RST_CYCLES=8, cycle 0 = first clk edge seeing `pll_locked` = 1.
1. Clean power-up: `pll_locked` rises at cycle 0 → `sys_rst_n` and `boot_rst_n` = 1 at cycle 18, `uart_rst_n` at 22, `core_rst_n` at 26, `seq_done` at 30.
2. Glitchy lock: `pll_locked` high 10 cycles, low 1 cycle, then high → stability count restarts. Releases occur 18 cycles after the final rise.
3. Lock loss in RUN: drop `pll_locked` → one cycle after `locked_s` falls, all four resets = 0 and `seq_done` = 0. Re-lock repeats scenario 1 timing.
4. Software reset: `sw_rst_req` pulse in RUN → `core_rst_n` = 0 for exactly 8 cycles, `boot_rst_n`/`uart_rst_n`/`sys_rst_n` stay 1. Pulse during REL_UART → no effect.
5. Simultaneous: `sw_rst_req` and lock loss on the same cycle in RUN → WAIT_LOCK, all resets asserted. `rst` pulsed mid-REL_UART → all outputs 0 immediately.
6. With RST_SEQ_WDOG_EN, LOCK_TIMEOUT=100, PLL_RST_CYCLES=8, `pll_locked` held 0 → `pll_rst` high cycles 100-107 after reset, repeating every 100 cycles. `lock_timeout` = 1 and stays 1 until REL_BOOT.
